// File: rtl/boot_writer_pkg.sv
// Shared definitions for boot_writer: FSM states, bootstrap image words and
// default placement of the image and start address.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_WRITE   = 3'd0,
    ST_VERIFY  = 3'd1,
    ST_NEXT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } boot_state_e;

  localparam int          BOOT_WORDS = 5;
  localparam logic [2:0]  LAST_INDEX = 3'(BOOT_WORDS - 1);

  localparam logic [11:0] IMG_W0 = 12'o7600;
  localparam logic [11:0] IMG_W1 = 12'o6603;
  localparam logic [11:0] IMG_W2 = 12'o6622;
  localparam logic [11:0] IMG_W3 = 12'o5352;
  localparam logic [11:0] IMG_W4 = 12'o5752;

  localparam logic [14:0] DEF_BASE_ADDR   = 15'o07750;
  localparam logic [11:0] DEF_START_PC    = 12'o7750;
  localparam logic [4:0]  DEF_ACK_TIMEOUT = 5'd15;

endpackage

// File: rtl/boot_writer_image.sv
// Bootstrap image ROM: maps a 3-bit word index to its 12-bit image word.
module boot_image
  import boot_pkg::*;
(
  input  logic [2:0]  i_index,
  output logic [11:0] o_word
);

  // Indices past the end of the image read as zero.
  always_comb begin
    o_word = 12'o0000;
    case (i_index)
      3'd0:    o_word = IMG_W0;
      3'd1:    o_word = IMG_W1;
      3'd2:    o_word = IMG_W2;
      3'd3:    o_word = IMG_W3;
      3'd4:    o_word = IMG_W4;
      default: o_word = 12'o0000;
    endcase
  end

endmodule

// File: rtl/boot_writer.sv
// Reset-time bus master that writes the bootstrap image into memory, then
// releases the CPU. Define BOOT_WRITER_VERIFY_EN to read back each word.
module boot_writer
  import boot_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [11:0] START_PC    = DEF_START_PC,
  parameter logic [4:0]  ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [11:0] mem_rdata,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic [11:0] start_pc,
  output logic        start_valid,
  output logic        done,
  output logic        err
);

  boot_state_e r_state;
  boot_state_e w_state_next;
  logic [2:0]  r_index;
  logic [2:0]  w_index_inc;
  logic [11:0] w_word_next;
  logic [4:0]  r_wait;
  logic [14:0] r_mem_addr;
  logic [11:0] r_mem_wdata;
  logic        r_mem_wr;
  logic        r_mem_rd;
  logic        r_cpu_hold;
  logic        r_start_valid;
  logic        r_done;
  logic        r_err;
  logic        w_req;
  logic        w_ack;
  logic        w_timeout;
  logic        w_last;

  boot_image u_image (
    .i_index (w_index_inc),
    .o_word  (w_word_next)
  );

  assign w_index_inc = r_index + 3'd1;
  assign w_last      = (r_index == LAST_INDEX);
  assign w_req       = r_mem_wr | r_mem_rd;
  // An ack only counts while a request is actually on the bus.
  assign w_ack       = w_req & mem_ack;
  assign w_timeout   = w_req & ~mem_ack & (r_wait == (ACK_TIMEOUT - 5'd1));

`ifdef BOOT_WRITER_VERIFY_EN
  logic w_verify_ok;
  assign w_verify_ok = (mem_rdata == r_mem_wdata);
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^mem_rdata;
`endif

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WRITE: begin
        if (w_ack) begin
`ifdef BOOT_WRITER_VERIFY_EN
          w_state_next = ST_VERIFY;
`else
          w_state_next = ST_NEXT;
`endif
        end else if (w_timeout) begin
          w_state_next = ST_ERROR;
        end else begin
          w_state_next = ST_WRITE;
        end
      end
      ST_VERIFY: begin
`ifdef BOOT_WRITER_VERIFY_EN
        if (w_ack) begin
          w_state_next = w_verify_ok ? ST_NEXT : ST_ERROR;
        end else if (w_timeout) begin
          w_state_next = ST_ERROR;
        end else begin
          w_state_next = ST_VERIFY;
        end
`else
        w_state_next = ST_ERROR;
`endif
      end
      ST_NEXT:    w_state_next = w_last ? ST_RELEASE : ST_WRITE;
      ST_RELEASE: w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_DONE;
      ST_ERROR:   w_state_next = ST_ERROR;
      default:    w_state_next = ST_ERROR;
    endcase
  end

  // State, counters and registered bus/CPU outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_WRITE;
      r_index       <= 3'd0;
      r_wait        <= 5'd0;
      r_mem_addr    <= BASE_ADDR;
      r_mem_wdata   <= IMG_W0;
      r_mem_wr      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_cpu_hold    <= 1'b1;
      r_start_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_mem_wr      <= (w_state_next == ST_WRITE);
`ifdef BOOT_WRITER_VERIFY_EN
      r_mem_rd      <= (w_state_next == ST_VERIFY);
`else
      r_mem_rd      <= 1'b0;
`endif
      r_cpu_hold    <= ~((w_state_next == ST_RELEASE) | (w_state_next == ST_DONE));
      r_start_valid <= (w_state_next == ST_RELEASE);
      r_done        <= (w_state_next == ST_DONE);
      r_err         <= (w_state_next == ST_ERROR);
      // Any completed or idle cycle restarts the wait count for the next access.
      r_wait        <= (w_req & ~mem_ack) ? (r_wait + 5'd1) : 5'd0;
      if ((r_state == ST_NEXT) && !w_last) begin
        r_index     <= w_index_inc;
        r_mem_addr  <= r_mem_addr + 15'd1;
        r_mem_wdata <= w_word_next;
      end else begin
        r_index     <= r_index;
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
      end
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wr      = r_mem_wr;
  assign mem_rd      = r_mem_rd;
  assign cpu_hold    = r_cpu_hold;
  assign start_pc    = START_PC;
  assign start_valid = r_start_valid;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_boot_writer.sv
// Self-checking bench for boot_writer: memory/ack model with programmable
// latency, directed scenarios with randomized ack delays.
module tb_boot_writer;

  localparam logic [14:0] BASE = 15'o07750;
  localparam logic [11:0] SPC  = 12'o7750;
`ifdef BOOT_WRITER_VERIFY_EN
  localparam int VERIFY_EN = 1;
`else
  localparam int VERIFY_EN = 0;
`endif
  localparam int ACC     = VERIFY_EN + 1;
  localparam int TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [11:0] mem_rdata;
  logic        mem_ack;
  logic        cpu_hold;
  logic [11:0] start_pc;
  logic        start_valid;
  logic        done;
  logic        err;

  boot_writer dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wr      (mem_wr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .cpu_hold    (cpu_hold),
    .start_pc    (start_pc),
    .start_valid (start_valid),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory / ack model. ack_mode: 0 = ack after ack_delay waits, 1 = never, 2 = always high.
  int          ack_mode;
  int          ack_delay;
  int          wait_cnt;
  logic        corrupt_en;
  logic [14:0] corrupt_addr;
  logic [11:0] corrupt_val;
  logic [11:0] mem_img [0:7];
  logic [14:0] off;
  logic [14:0] wr_addr_q [$];
  logic [11:0] wr_data_q [$];
  int          rd_count;
  int          stab_err;
  int          both_err;
  logic        prev_req;
  logic        prev_ack;
  logic [14:0] prev_addr;
  logic [11:0] prev_wdata;

  assign off       = mem_addr - BASE;
  assign mem_rdata = (off < 15'd8) ? mem_img[off[2:0]] : 12'o0000;
  assign mem_ack   = (ack_mode == 2) ||
                     ((ack_mode == 0) && (mem_wr || mem_rd) && (wait_cnt >= ack_delay));

  initial begin
    wait_cnt = 0; rd_count = 0; stab_err = 0; both_err = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 15'd0; prev_wdata = 12'd0;
    for (int i = 0; i < 8; i++) mem_img[i] = 12'o0000;
  end

  always @(posedge clk) begin
    if ((mem_wr || mem_rd) && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (mem_wr && mem_ack) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      if (off < 15'd8)
        mem_img[off[2:0]] <= (corrupt_en && (mem_addr == corrupt_addr)) ? corrupt_val : mem_wdata;
    end
    if (mem_rd && mem_ack) rd_count <= rd_count + 1;
    if (mem_wr && mem_rd) both_err <= both_err + 1;
    if ((mem_wr || mem_rd) && prev_req && !prev_ack &&
        ((mem_addr != prev_addr) || (mem_wdata != prev_wdata)))
      stab_err <= stab_err + 1;
    prev_req   <= mem_wr || mem_rd;
    prev_ack   <= mem_ack;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
  end

  int          n_checks;
  int          n_fail;
  logic [11:0] img_ref [0:4];
  int          wr_base, rd_base, stab_base, both_base;
  int          rel_cyc, sv_pulses, hold_low, done_cyc, err_cyc, first_wr, wr_high;
  int          finished;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d (o%0o) expected=%0d (o%0o)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  // One reset edge; on return the bench sits in cycle 0 with reset low.
  task automatic start_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wr_base   = wr_addr_q.size();
    rd_base   = rd_count;
    stab_base = stab_err;
    both_base = both_err;
    chk({tag, "_rst_wr"},    32'(mem_wr), 32'd0);
    chk({tag, "_rst_rd"},    32'(mem_rd), 32'd0);
    chk({tag, "_rst_hold"},  32'(cpu_hold), 32'd1);
    chk({tag, "_rst_sv"},    32'(start_valid), 32'd0);
    chk({tag, "_rst_done"},  32'(done), 32'd0);
    chk({tag, "_rst_err"},   32'(err), 32'd0);
    chk({tag, "_rst_addr"},  32'(mem_addr), 32'(BASE));
    chk({tag, "_rst_wdata"}, 32'(mem_wdata), 32'(img_ref[0]));
  endtask

  task automatic run_load(input string tag, input int max_cyc);
    int tail;
    rel_cyc = -1; sv_pulses = 0; hold_low = -1; done_cyc = -1; err_cyc = -1;
    first_wr = -1; wr_high = 0; tail = 0; finished = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      if (start_valid) begin sv_pulses++; if (rel_cyc < 0) rel_cyc = c; end
      if (!cpu_hold && hold_low < 0) hold_low = c;
      if (done && done_cyc < 0) done_cyc = c;
      if (err && err_cyc < 0) err_cyc = c;
      if (mem_wr) begin wr_high++; if (first_wr < 0) first_wr = c; end
      if (done || err) begin
        tail++;
        if (tail > 3) begin finished = 1; break; end
      end
    end
    chk({tag, "_end_bound"}, 32'(finished), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    chk({tag, "_nwr"}, 32'(wr_addr_q.size() - wr_base), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (wr_base + i < wr_addr_q.size()) begin
        chk($sformatf("%s_wa%0d", tag, i), 32'(wr_addr_q[wr_base + i]), 32'(BASE + 15'(i)));
        chk($sformatf("%s_wd%0d", tag, i), 32'(wr_data_q[wr_base + i]), 32'(img_ref[i]));
      end
    end
    chk({tag, "_stable"}, 32'(stab_err - stab_base), 32'd0);
    chk({tag, "_excl"},   32'(both_err - both_base), 32'd0);
  endtask

  // Successful load where every access is acked after d wait cycles.
  task automatic check_ok(input string tag, input int d);
    int exp_rel;
    exp_rel = 1 + 5 * (ACC * (d + 1) + 1);
    check_writes(tag, 5);
    chk({tag, "_first_wr"}, 32'(first_wr), 32'd1);
    chk({tag, "_rel_cyc"},  32'(rel_cyc), 32'(exp_rel));
    chk({tag, "_sv_once"},  32'(sv_pulses), 32'd1);
    chk({tag, "_hold_low"}, 32'(hold_low), 32'(exp_rel));
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_rel + 1));
    chk({tag, "_no_err"},   32'(err_cyc), 32'hFFFF_FFFF);
    chk({tag, "_reads"},    32'(rd_count - rd_base), 32'(VERIFY_EN * 5));
    chk({tag, "_spc"},      32'(start_pc), 32'(SPC));
    chk({tag, "_hold_end"}, 32'(cpu_hold), 32'd0);
  endtask

  int d;
  int reached;

  initial begin
    n_checks = 0; n_fail = 0;
    img_ref[0] = 12'o7600; img_ref[1] = 12'o6603; img_ref[2] = 12'o6622;
    img_ref[3] = 12'o5352; img_ref[4] = 12'o5752;
    reset = 1'b1; ack_mode = 0; ack_delay = 0;
    corrupt_en = 1'b0; corrupt_addr = 15'o07752; corrupt_val = 12'o6623;
    repeat (2) @(posedge clk);

    // Zero-wait ack.
    start_reset("s1");
    run_load("s1", 400);
    check_ok("s1", 0);

    // Three wait cycles per access.
    ack_delay = 3;
    start_reset("s2");
    run_load("s2", 400);
    check_ok("s2", 3);

    // Random latencies.
    for (int k = 0; k < 3; k++) begin
      d = $urandom_range(0, 9);
      ack_delay = d;
      start_reset($sformatf("rnd%0d", k));
      run_load($sformatf("rnd%0d", k), 400);
      check_ok($sformatf("rnd%0d_d%0d", k, d), d);
    end

    // Ack arrives on the same edge the wait count reaches the limit.
    ack_delay = TIMEOUT - 1;
    start_reset("edge");
    run_load("edge", 600);
    check_ok("edge", TIMEOUT - 1);

    // Ack never arrives: timeout in the first write.
    ack_mode = 1;
    start_reset("s3");
    run_load("s3", 400);
    chk("s3_err_cyc",  32'(err_cyc), 32'(TIMEOUT + 1));
    chk("s3_wr_high",  32'(wr_high), 32'(TIMEOUT));
    chk("s3_sv",       32'(sv_pulses), 32'd0);
    chk("s3_done",     32'(done), 32'd0);
    chk("s3_hold",     32'(cpu_hold), 32'd1);
    chk("s3_wr_end",   32'(mem_wr), 32'd0);
    chk("s3_nwr",      32'(wr_addr_q.size() - wr_base), 32'd0);

    // Memory corrupts 07752; only a verifying build notices.
    ack_mode = 0;
    d = $urandom_range(0, 2);
    ack_delay = d;
    corrupt_en = 1'b1;
    start_reset("s4");
    run_load("s4", 400);
    if (VERIFY_EN != 0) begin
      check_writes("s4", 3);
      chk("s4_err_cyc", 32'(err_cyc), 32'(1 + 2 * (2 * (d + 1) + 1) + 2 * (d + 1)));
      chk("s4_reads",   32'(rd_count - rd_base), 32'd3);
      chk("s4_sv",      32'(sv_pulses), 32'd0);
      chk("s4_hold",    32'(cpu_hold), 32'd1);
      chk("s4_err",     32'(err), 32'd1);
      chk("s4_wr_end",  32'(mem_wr), 32'd0);
      chk("s4_rd_end",  32'(mem_rd), 32'd0);
    end else begin
      check_ok("s4", d);
    end
    corrupt_en = 1'b0;

    // Reset once 07751 has been written; load restarts from 07750.
    ack_delay = 0;
    start_reset("s5a");
    reached = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (wr_addr_q.size() - wr_base >= 2) begin reached = 1; break; end
    end
    chk("s5_reach_w1", 32'(reached), 32'd1);
    start_reset("s5b");
    run_load("s5", 400);
    check_ok("s5", 0);

    // Ack stuck high, including across reset.
    ack_mode = 2;
    start_reset("s6");
    run_load("s6", 400);
    check_ok("s6", 0);

    // Reset from DONE re-holds the CPU and reloads.
    ack_mode = 0;
    d = $urandom_range(0, 5);
    ack_delay = d;
    start_reset("s7");
    run_load("s7", 400);
    check_ok($sformatf("s7_d%0d", d), d);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_writer.md
# boot_writer

Reset-time bus master that deposits the TSS/8 bootstrap directly into main memory, instead of the CPU copying it out of a ROM page. While it loads, it holds the CPU off the bus. It then releases the CPU with a start address.
- Image: five words, written to 07750–07754.
- Start PC: 7750.
- Sits between the reset controller and the memory arbiter, as a second master alongside the CPU.

## Interface
Parameters:
- BASE_ADDR, 15'o07750, field/address of the first image word
- START_PC, 12'o7750, PC presented to the CPU on release
- ACK_TIMEOUT, 5'd15, max cycles waiting for mem_ack per access before error

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mem_addr  out  15  access address
- mem_wdata  out  12  write data
- mem_wr  out  1  write request, held until acked
- mem_rd  out  1  read request, held until acked (verify only; 0 otherwise)
- mem_rdata  in  12  read data, valid with mem_ack on a read
- mem_ack  in  1  access complete; ignored while mem_wr=mem_rd=0
- cpu_hold  out  1  CPU must not fetch while 1
- start_pc  out  12  constant START_PC
- start_valid  out  1  one-cycle pulse: CPU loads start_pc
- done  out  1  sticky, load finished OK
- err  out  1  sticky, timeout or verify mismatch

## Operation
- Image, in index order 0..4: 7600, 6603, 6622, 5352, 5752.
  - Word i goes to BASE_ADDR+i.
  - Index counter is 3 bits.
  - Address arithmetic is 15-bit and wraps modulo 2^15.
- States:
  - WRITE: mem_wr=1. Ack → VERIFY if enabled, else NEXT.
  - VERIFY: mem_rd=1. On ack, compare mem_rdata with the image word; mismatch → ERROR, match → NEXT.
  - NEXT: no request. Increment index; index was 4 → RELEASE, else → WRITE.
  - RELEASE: start_valid=1, cpu_hold→0. → DONE.
  - DONE: terminal. done=1, cpu_hold=0.
  - ERROR: terminal. err=1, cpu_hold stays 1, no requests.
- Timeout:
  - The cycle counter clears on entry to WRITE or VERIFY and increments each cycle without ack.
  - Reaching ACK_TIMEOUT without ack → ERROR.
  - An ack on the same edge the count reaches ACK_TIMEOUT wins.
- mem_addr and mem_wdata are stable for the whole of a request.
- mem_wr and mem_rd are never both 1.

## Timing
- Reset values:
  - State WRITE, index 0, mem_addr=BASE_ADDR, mem_wdata=7600.
  - mem_wr=0, mem_rd=0, cpu_hold=1, start_valid=0, done=0, err=0.
- All outputs are registered.
- mem_wr rises on the first edge after reset deasserts.
- An ack sampled high on the same edge mem_wr is high completes the access. A combinational same-cycle ack is legal.
- The request drops on the edge following the ack.
- Per word, with zero-wait ack: 2 cycles without verify, 3 with verify.
- Full load with zero-wait ack:
  - Without verify: RELEASE in cycle 11 after reset, i.e. start_valid high in cycle 11 and cpu_hold low from cycle 11.
  - With verify: RELEASE in cycle 16.
- done is 1 from the cycle after RELEASE.
- Reset mid-load aborts immediately. The next edge returns to reset values and the load restarts at index 0; partially written words are simply overwritten.
- reset asserted in DONE re-holds the CPU and reloads.

## Configuration
- BOOT_WRITER_VERIFY_EN defined: the VERIFY state is present and each word is read back after its write.
- Undefined:
  - The VERIFY state is removed and mem_rd is tied 0.
  - mem_rdata is unused.
  - err can only come from a write timeout.
- Ports are identical in both builds.

## Structure
- Package boot_pkg:
  - State enum.
  - BOOT_WORDS=5.
  - Image word constants.
  - Default BASE_ADDR and START_PC.
- Sub-module boot_image: combinational index[2:0] → 12-bit word. Unused indices return 0000.
- The FSM, counters and bus drivers live in boot_writer.

## Test plan
1. Zero-wait ack, verify off → writes 07750=7600, 07751=6603, 07752=6622, 07753=5352, 07754=5752 in order; start_valid single pulse in cycle 11; start_pc=7750; done=1, err=0.
2. Ack delayed 3 cycles per access → mem_addr/mem_wdata stable while mem_wr=1; same five writes; completion delayed accordingly.
3. mem_ack never asserted → after 15 cycles in WRITE: err=1, cpu_hold=1, mem_wr=0, start_valid never pulses.
4. Verify on, memory model corrupts 07752 to 6623 → write then read of 07752, mismatch → ERROR; err=1; no write to 07753.
5. reset pulsed after the write of 07751 → mem_wr=0 next cycle; load restarts at 07750; finishes normally.
6. mem_ack held high permanently with no request outstanding, before reset release → no spurious completion; load order and timing identical to scenario 1.
